// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Requester IDs: CPU path and program loader / debug port.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response handshake for both requesters plus the memory-side bus.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic              req0_valid;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req0_done;
  logic [DATA_W-1:0] req0_rdata;

  logic              req1_valid;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              req1_done;
  logic [DATA_W-1:0] req1_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Requesters and the memory array.
  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, req0_done, req0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, req1_done, req1_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

  // The arbiter itself.
  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, req0_done, req0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, req1_done, req1_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational 2-way arbiter: round-robin or fixed priority (requester 0).
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Under contention pick the requester that did not win last time.
  always_comb begin
    grant = '0;
    if (valid == 2'b11) begin
      if (ROUND_ROBIN != 0) begin
        grant = (last_grant == REQ_LDR) ? 2'b01 : 2'b10;
      end else begin
        grant = 2'b01;
      end
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for a single-port memory with
// combinational read and level-sensitive write enable.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ROUND_ROBIN = 1
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        grant;
  logic              accept;
  logic              acc_id;
  logic              last_grant;
  logic              gnt_id;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [1:0]        done_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  rr_arb2 #(
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_arb (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign acc_id = grant[1] ? REQ_LDR : REQ_CPU;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and accept; ready is gated by reset so it is 0 while rst_n=0.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (grant != 2'b00)) begin
          accept    = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, memory bus registers, completion pulses and read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant  <= REQ_LDR;
      gnt_id      <= REQ_CPU;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      done_q   <= '0;
      mem_we_q <= 1'b0;
      if (accept) begin
        gnt_id      <= acc_id;
        last_grant  <= acc_id;
        mem_we_q    <= (acc_id == REQ_LDR) ? bus.req1_we    : bus.req0_we;
        mem_addr_q  <= (acc_id == REQ_LDR) ? bus.req1_addr  : bus.req0_addr;
        mem_wdata_q <= (acc_id == REQ_LDR) ? bus.req1_wdata : bus.req0_wdata;
      end
      if (state == ACCESS) begin
        done_q[gnt_id] <= 1'b1;
        if (!mem_we_q) begin
          if (gnt_id == REQ_LDR) begin
            rdata1_q <= bus.mem_rdata;
          end else begin
            rdata0_q <= bus.mem_rdata;
          end
        end
      end
    end
  end

  assign bus.req0_ready = accept & grant[0];
  assign bus.req1_ready = accept & grant[1];
  assign bus.req0_done  = done_q[0];
  assign bus.req1_done  = done_q[1];
  assign bus.req0_rdata = rdata0_q;
  assign bus.req1_rdata = rdata1_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.busy       = (state == ACCESS);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random
// traffic compared against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic rst_n;
  logic mem_clear;
  int   n_assert = 0;
  int   n_fail   = 0;

  mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_fp ();

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .ROUND_ROBIN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .ROUND_ROBIN(0)) dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fp)
  );

  // Memory array attached to the round-robin instance.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 11);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata    = mem[bus.mem_addr];
  assign bus_fp.mem_rdata = 8'h5A;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state (transaction level).
  bit         pend [2];
  bit         pwe [2];
  logic [7:0] paddr [2];
  logic [7:0] pwdata [2];
  bit         phase;
  int         cur_id;
  bit         cur_we;
  logic [7:0] cur_addr;
  logic [7:0] cur_wdata;
  logic [7:0] cur_rd;
  bit   [1:0] done_exp;
  logic [7:0] rd_hold [2];
  int         last_w;
  logic [7:0] ref_mem [256];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int id, input bit we, input logic [7:0] a, input logic [7:0] d);
    pend[id]   = 1'b1;
    pwe[id]    = we;
    paddr[id]  = a;
    pwdata[id] = d;
  endtask

  task automatic drive_reqs();
    bus.req0_valid = pend[0];
    bus.req0_we    = pwe[0];
    bus.req0_addr  = paddr[0];
    bus.req0_wdata = pwdata[0];
    bus.req1_valid = pend[1];
    bus.req1_we    = pwe[1];
    bus.req1_addr  = paddr[1];
    bus.req1_wdata = pwdata[1];
  endtask

  // One clock cycle: check registered outputs, drive requests, check ready,
  // advance the model, wait for the next edge.
  task automatic cycle();
    bit has_w;
    int w;
    chk("busy",   8'(bus.busy),   8'(phase));
    chk("mem_we", 8'(bus.mem_we), 8'(phase && cur_we));
    if (phase) begin
      chk("mem_addr", bus.mem_addr, cur_addr);
      if (cur_we) chk("mem_wdata", bus.mem_wdata, cur_wdata);
    end
    chk("done0",  8'(bus.req0_done), 8'(done_exp[0]));
    chk("done1",  8'(bus.req1_done), 8'(done_exp[1]));
    chk("rdata0", bus.req0_rdata, rd_hold[0]);
    chk("rdata1", bus.req1_rdata, rd_hold[1]);
    drive_reqs();
    #1;
    has_w = 1'b0;
    w     = 0;
    if (!phase) begin
      if (pend[0] && pend[1]) begin
        has_w = 1'b1;
        w     = 1 - last_w;
      end else if (pend[0]) begin
        has_w = 1'b1;
        w     = 0;
      end else if (pend[1]) begin
        has_w = 1'b1;
        w     = 1;
      end
    end
    chk("ready0", 8'(bus.req0_ready), 8'(has_w && w == 0));
    chk("ready1", 8'(bus.req1_ready), 8'(has_w && w == 1));
    done_exp = '0;
    if (phase) begin
      done_exp[cur_id] = 1'b1;
      if (!cur_we) rd_hold[cur_id] = cur_rd;
      phase = 1'b0;
    end else if (has_w) begin
      cur_id    = w;
      cur_we    = pwe[w];
      cur_addr  = paddr[w];
      cur_wdata = pwdata[w];
      if (cur_we) ref_mem[cur_addr] = cur_wdata;
      else        cur_rd = ref_mem[cur_addr];
      pend[w] = 1'b0;
      last_w  = w;
      phase   = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    pend[0] = 1'b0;  pend[1] = 1'b0;
    phase    = 1'b0;
    done_exp = '0;
    rd_hold[0] = '0; rd_hold[1] = '0;
    last_w   = 1;
    cur_id   = 0;
    cur_we   = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_clear = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    for (int i = 0; i < 2; i++) begin
      pwe[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
    end
    model_reset();
    bus_fp.req0_valid = 1'b0; bus_fp.req0_we = 1'b0; bus_fp.req0_addr = '0; bus_fp.req0_wdata = '0;
    bus_fp.req1_valid = 1'b0; bus_fp.req1_we = 1'b0; bus_fp.req1_addr = '0; bus_fp.req1_wdata = '0;

    // Reset held with both requesters valid.
    new_req(0, 1'b0, 8'h20, 8'h00);
    new_req(1, 1'b0, 8'h30, 8'h00);
    drive_reqs();
    #1;
    chk("rst_ready0", 8'(bus.req0_ready), 8'h00);
    chk("rst_ready1", 8'(bus.req1_ready), 8'h00);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_ready0", 8'(bus.req0_ready), 8'h00);
      chk("rst_ready1", 8'(bus.req1_ready), 8'h00);
      chk("rst_done0",  8'(bus.req0_done),  8'h00);
      chk("rst_done1",  8'(bus.req1_done),  8'h00);
      chk("rst_mem_we", 8'(bus.mem_we),     8'h00);
      chk("rst_addr",   bus.mem_addr,       8'h00);
      chk("rst_wdata",  bus.mem_wdata,      8'h00);
      chk("rst_busy",   8'(bus.busy),       8'h00);
      chk("rst_rdata0", bus.req0_rdata,     8'h00);
      chk("rst_rdata1", bus.req1_rdata,     8'h00);
    end
    mem_clear = 1'b0;
    rst_n     = 1'b1;
    #1;
    chk("first_grant0", 8'(bus.req0_ready), 8'h01);
    chk("first_grant1", 8'(bus.req1_ready), 8'h00);
    repeat (6) cycle();

    // Single write then read back from requester 0.
    new_req(0, 1'b1, 8'h10, 8'hA5);
    repeat (3) cycle();
    new_req(0, 1'b0, 8'h10, 8'h00);
    repeat (3) cycle();
    chk("rd_after_wr", bus.req0_rdata, 8'hA5);

    // Continuous contention under round-robin.
    repeat (10) begin
      if (!pend[0]) new_req(0, 1'b0, 8'h01, 8'h00);
      if (!pend[1]) new_req(1, 1'b0, 8'h02, 8'h00);
      cycle();
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    repeat (3) cycle();

    // Cross-requester read-after-write at the top address.
    new_req(1, 1'b1, 8'hFF, 8'h3C);
    cycle();
    new_req(0, 1'b0, 8'hFF, 8'h00);
    repeat (4) cycle();
    chk("raw_cross", bus.req0_rdata, 8'h3C);

    // Random traffic.
    repeat (400) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0)
          new_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom));
      end
      cycle();
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    repeat (3) cycle();

    // Reset asserted during ACCESS of a read.
    new_req(0, 1'b0, 8'h40, 8'h00);
    cycle();
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_done0",  8'(bus.req0_done), 8'h00);
    chk("mrst_rdata0", bus.req0_rdata,    8'h00);
    chk("mrst_rdata1", bus.req1_rdata,    8'h00);
    chk("mrst_busy",   8'(bus.busy),      8'h00);
    chk("mrst_mem_we", 8'(bus.mem_we),    8'h00);
    chk("mrst_ready0", 8'(bus.req0_ready), 8'h00);
    @(posedge clk);
    #1;
    chk("mrst_done0b", 8'(bus.req0_done), 8'h00);
    rst_n = 1'b1;
    model_reset();
    new_req(0, 1'b0, 8'h40, 8'h00);
    repeat (3) cycle();
    chk("reissue_rd", bus.req0_rdata, ref_mem[8'h40]);

    // Fixed priority: requester 1 starves while requester 0 stays valid.
    bus_fp.req0_valid = 1'b1; bus_fp.req0_addr = 8'h01;
    bus_fp.req1_valid = 1'b1; bus_fp.req1_addr = 8'h02;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("fp_ready1", 8'(bus_fp.req1_ready), 8'h00);
      chk("fp_ready0", 8'(bus_fp.req0_ready), 8'((k % 2) == 0));
      @(posedge clk);
      #1;
    end
    bus_fp.req0_valid = 1'b0;
    #1;
    chk("fp_ready1_free", 8'(bus_fp.req1_ready), 8'h01);
    chk("fp_ready0_off",  8'(bus_fp.req0_ready), 8'h00);
    @(posedge clk);
    #1;
    bus_fp.req1_valid = 1'b0;
    chk("fp_busy", 8'(bus_fp.busy), 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
